// File: rtl/tcm_mem.sv
// Tightly-coupled 128 KiB memory: 64-bit instruction fetch port plus 32-bit data port.
// Both ports answer every request one cycle later; reads are read-first with respect to writes.
module tcm_mem (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        mem_i_rd_i,
  input  logic        mem_i_flush_i,
  input  logic        mem_i_invalidate_i,
  input  logic [31:0] mem_i_pc_i,

  input  logic [31:0] mem_d_addr_i,
  input  logic [31:0] mem_d_data_wr_i,
  input  logic        mem_d_rd_i,
  input  logic [3:0]  mem_d_wr_i,
  input  logic        mem_d_cacheable_i,
  input  logic [10:0] mem_d_req_tag_i,
  input  logic        mem_d_invalidate_i,
  input  logic        mem_d_writeback_i,
  input  logic        mem_d_flush_i,

  output logic        mem_i_accept_o,
  output logic        mem_i_valid_o,
  output logic        mem_i_error_o,
  output logic [63:0] mem_i_inst_o,

  output logic [31:0] mem_d_data_rd_o,
  output logic        mem_d_accept_o,
  output logic        mem_d_ack_o,
  output logic        mem_d_error_o,
  output logic [10:0] mem_d_resp_tag_o
);

  localparam int unsigned WORDS  = 16384;
  localparam int unsigned IDX_W  = 14;
  localparam int unsigned WORD_W = 64;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 11;
  localparam int unsigned LANES  = 4;

  logic [WORD_W-1:0] ram [WORDS];

  logic [IDX_W-1:0] i_idx;
  logic [IDX_W-1:0] d_idx;
  logic             d_req_c;

  assign i_idx   = mem_i_pc_i[16:3];
  assign d_idx   = mem_d_addr_i[16:3];
  assign d_req_c = mem_d_rd_i | (|mem_d_wr_i) | mem_d_flush_i |
                   mem_d_invalidate_i | mem_d_writeback_i;

  assign mem_i_accept_o = 1'b1;
  assign mem_d_accept_o = 1'b1;
  assign mem_i_error_o  = 1'b0;
  assign mem_d_error_o  = 1'b0;

  // Storage is never reset; byte lanes land in the half selected by addr[2].
  always @(posedge clk_i) begin : ram_write
    for (int n = 0; n < LANES; n++) begin
      if (mem_d_wr_i[n]) begin
        ram[d_idx][{mem_d_addr_i[2], 2'(n), 3'b000} +: 8] <= mem_d_data_wr_i[n*8 +: 8];
      end
    end
  end

  // Response registers; reset clears them immediately and drops any pending response.
  always_ff @(posedge clk_i or posedge rst_i) begin : resp_regs
    if (rst_i) begin
      mem_i_valid_o    <= 1'b0;
      mem_i_inst_o     <= '0;
      mem_d_ack_o      <= 1'b0;
      mem_d_resp_tag_o <= '0;
      mem_d_data_rd_o  <= '0;
    end else begin
      mem_i_valid_o <= mem_i_rd_i;
      if (mem_i_rd_i) begin
        mem_i_inst_o <= ram[i_idx];
      end
      mem_d_ack_o <= d_req_c;
      if (d_req_c) begin
        mem_d_resp_tag_o <= TAG_W'(mem_d_req_tag_i);
        mem_d_data_rd_o  <= mem_d_addr_i[2] ? ram[d_idx][WORD_W-1:DATA_W]
                                            : ram[d_idx][DATA_W-1:0];
      end
    end
  end

  // Preload hook: stores one byte at addr[16:0], independent of clock and reset.
  task automatic write(input logic [31:0] addr, input logic [7:0] data);
    logic unused_hi;
    unused_hi = ^addr[31:17];
    ram[addr[16:3]][{addr[2:0], 3'b000} +: 8] <= data;
  endtask

  logic unused_in;
  assign unused_in = ^{mem_i_flush_i, mem_i_invalidate_i, mem_d_cacheable_i,
                       mem_i_pc_i[31:17], mem_i_pc_i[2:0],
                       mem_d_addr_i[31:17], mem_d_addr_i[1:0]};

endmodule

// File: tb/tb_tcm_mem.sv
// Self-checking bench for tcm_mem: byte-array reference model, directed cases, random traffic.
module tb_tcm_mem;

  logic        clk;
  logic        rst;
  logic        i_rd, i_flush, i_inv;
  logic [31:0] pc;
  logic [31:0] d_addr, d_wdata;
  logic        d_rd;
  logic [3:0]  d_wr;
  logic        d_cache;
  logic [10:0] d_tag;
  logic        d_inv, d_wb, d_flush;

  logic        i_acc, i_valid, i_err;
  logic [63:0] i_inst;
  logic [31:0] d_rdata;
  logic        d_acc, d_ack, d_err;
  logic [10:0] d_rtag;

  tcm_mem dut (
    .clk_i(clk), .rst_i(rst),
    .mem_i_rd_i(i_rd), .mem_i_flush_i(i_flush), .mem_i_invalidate_i(i_inv), .mem_i_pc_i(pc),
    .mem_d_addr_i(d_addr), .mem_d_data_wr_i(d_wdata), .mem_d_rd_i(d_rd), .mem_d_wr_i(d_wr),
    .mem_d_cacheable_i(d_cache), .mem_d_req_tag_i(d_tag),
    .mem_d_invalidate_i(d_inv), .mem_d_writeback_i(d_wb), .mem_d_flush_i(d_flush),
    .mem_i_accept_o(i_acc), .mem_i_valid_o(i_valid), .mem_i_error_o(i_err), .mem_i_inst_o(i_inst),
    .mem_d_data_rd_o(d_rdata), .mem_d_accept_o(d_acc), .mem_d_ack_o(d_ack),
    .mem_d_error_o(d_err), .mem_d_resp_tag_o(d_rtag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: flat byte array plus the expected response registers.
  logic [7:0]  mem_m [131072];
  logic        e_iv = 1'b0;
  logic        e_ack = 1'b0;
  logic [10:0] e_tag = '0;
  logic [31:0] e_data = '0;
  logic [63:0] e_inst = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] m_word(input logic [31:0] a);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[b*8 +: 8] = mem_m[{a[16:3], 3'(b)}];
    return r;
  endfunction

  function automatic logic [31:0] m_half(input logic [31:0] a);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = mem_m[{a[16:2], 2'(b)}];
    return r;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] v);
    dut.write(a, v);
    mem_m[a[16:0]] = v;
  endtask

  task automatic idle();
    i_rd = 0; i_flush = 0; i_inv = 0; pc = '0;
    d_addr = '0; d_wdata = '0; d_rd = 0; d_wr = '0; d_cache = 0;
    d_tag = '0; d_inv = 0; d_wb = 0; d_flush = 0;
  endtask

  task automatic set_d(input logic rd, input logic [3:0] wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [10:0] t);
    d_rd = rd; d_wr = wr; d_addr = a; d_wdata = d; d_tag = t;
  endtask

  // One clock: predict from current inputs and pre-write model, then publish after the edge.
  task automatic cycle();
    logic        n_iv, n_ack, req;
    logic [10:0] n_tag;
    logic [31:0] n_data;
    logic [63:0] n_inst;
    n_iv = e_iv; n_ack = e_ack; n_tag = e_tag; n_data = e_data; n_inst = e_inst;
    if (rst) begin
      n_iv = 0; n_ack = 0; n_tag = '0; n_data = '0; n_inst = '0;
    end else begin
      req   = d_rd | (|d_wr) | d_flush | d_inv | d_wb;
      n_iv  = i_rd;
      n_ack = req;
      if (i_rd) n_inst = m_word(pc);
      if (req) begin
        n_tag  = d_tag;
        n_data = m_half(d_addr);
      end
    end
    @(posedge clk);
    if (!rst)
      for (int n = 0; n < 4; n++)
        if (d_wr[n]) mem_m[{d_addr[16:2], 2'(n)}] = d_wdata[n*8 +: 8];
    e_iv = n_iv; e_ack = n_ack; e_tag = n_tag; e_data = n_data; e_inst = n_inst;
    #1;
  endtask

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("i_valid", 64'(i_valid), 64'(e_iv));
      chk("d_ack", 64'(d_ack), 64'(e_ack));
      if (e_ack) chk("d_resp_tag", 64'(d_rtag), 64'(e_tag));
      chk("d_data_rd", 64'(d_rdata), 64'(e_data));
      chk("i_inst", i_inst, e_inst);
      chk("accept_error", 64'({i_acc, d_acc, i_err, d_err}), 64'(4'b1100));
    end
  end

  initial begin
    logic [31:0] r, a;
    rst = 1'b1;
    idle();
    #3;
    chk("reset_outputs", {i_valid, d_ack, d_rtag, d_rdata}, 64'h0);
    chk("reset_inst", i_inst, 64'h0);

    // Preload everything while reset is held.
    for (int o = 0; o < 131072; o++) begin
      r = $urandom;
      preload(32'(o), r[7:0]);
    end
    preload(32'h0, 8'h13); preload(32'h1, 8'h00); preload(32'h2, 8'h00); preload(32'h3, 8'h00);
    preload(32'h4, 8'h93); preload(32'h5, 8'h00); preload(32'h6, 8'h10); preload(32'h7, 8'h00);
    preload(32'h200, 8'h44); preload(32'h201, 8'h33); preload(32'h202, 8'h22); preload(32'h203, 8'h11);
    cycle(); cycle();
    rst = 1'b0;

    i_rd = 1; pc = 32'h8000_0000;
    cycle();
    chk("fetch_valid", 64'(i_valid), 64'h1);
    chk("fetch_inst", i_inst, 64'h0010_0093_0000_0013);
    chk("model_fetch_inst", e_inst, 64'h0010_0093_0000_0013);

    i_rd = 0;
    set_d(0, 4'hF, 32'h8000_0104, 32'hDEAD_BEEF, 11'h155);
    cycle();
    chk("wr_ack", 64'(d_ack), 64'h1);
    chk("wr_tag", 64'(d_rtag), 64'h155);

    set_d(1, 4'h0, 32'h8000_0104, 32'h0, 11'h001);
    i_rd = 1; pc = 32'h8000_0100;
    cycle();
    chk("rd_after_wr", 64'(d_rdata), 64'hDEAD_BEEF);
    chk("fetch_hi_half", 64'(i_inst[63:32]), 64'hDEAD_BEEF);

    i_rd = 0;
    set_d(0, 4'h5, 32'h0000_0200, 32'hAABB_CCDD, 11'h002);
    cycle();
    chk("partial_wr_readfirst", 64'(d_rdata), 64'h1122_3344);
    set_d(1, 4'h0, 32'h0000_0200, 32'h0, 11'h003);
    cycle();
    chk("partial_wr_merge", 64'(d_rdata), 64'h11BB_33DD);
    chk("model_partial_merge", 64'(e_data), 64'h11BB_33DD);

    set_d(1, 4'h0, 32'h8002_0010, 32'h0, 11'h004);
    cycle();
    chk("wrap_alias", 64'(d_rdata), 64'(m_half(32'h8000_0010)));

    set_d(0, 4'h0, 32'h8000_0104, 32'h1234_5678, 11'h7FF);
    d_flush = 1;
    cycle();
    chk("flush_ack", 64'(d_ack), 64'h1);
    chk("flush_tag", 64'(d_rtag), 64'h7FF);
    d_flush = 0;
    set_d(1, 4'h0, 32'h8000_0104, 32'h0, 11'h005);
    cycle();
    chk("flush_no_change", 64'(d_rdata), 64'hDEAD_BEEF);

    // Same-cycle fetch and write to one word: fetch sees old data, then new.
    set_d(0, 4'hF, 32'h0000_0304, 32'hCAFE_F00D, 11'h006);
    i_rd = 1; pc = 32'h0000_0300;
    cycle();
    set_d(0, 4'h0, 32'h0, 32'h0, 11'h0);
    cycle();
    chk("fetch_after_wr", 64'(i_inst[63:32]), 64'hCAFE_F00D);

    // Reset mid-request: outputs clear without a clock edge, pending response is dropped.
    set_d(1, 4'h0, 32'h8000_0000, 32'h0, 11'h0AA);
    i_rd = 1; pc = 32'h8000_0000;
    cycle();
    chk("pre_reset_ack", 64'(d_ack), 64'h1);
    #2;
    rst = 1'b1;
    e_iv = 0; e_ack = 0; e_tag = '0; e_data = '0; e_inst = '0;
    #1;
    chk("async_reset_clear", {i_valid, d_ack, d_rtag, d_rdata}, 64'h0);
    chk("async_reset_inst", i_inst, 64'h0);
    idle();
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    chk("no_ack_after_release", 64'({i_valid, d_ack}), 64'h0);
    set_d(1, 4'h0, 32'h8000_0000, 32'h0, 11'h00B);
    i_rd = 1; pc = 32'h8000_0000;
    cycle();
    chk("data_kept_rd", 64'(d_rdata), 64'h0000_0013);
    chk("data_kept_fetch", i_inst, 64'h0010_0093_0000_0013);

    // Random traffic, full address range with random alias bits.
    for (int k = 0; k < 4000; k++) begin
      r = $urandom;
      i_rd = r[0]; i_flush = r[1]; i_inv = r[2]; d_cache = r[3];
      d_rd = r[4] & r[5];
      d_wr = (r[7:6] == 2'b00) ? r[11:8] : 4'h0;
      d_flush = (r[15:12] == 4'h0); d_inv = (r[15:12] == 4'h1); d_wb = (r[15:12] == 4'h2);
      d_tag = r[26:16];
      a = $urandom; pc = a;
      a = $urandom;
      if (r[27]) a[16:5] = 12'h000;
      d_addr = a;
      d_wdata = $urandom;
      if (r[28]) pc = d_addr;
      cycle();
    end
    idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tcm_mem.md
TCM_MEM -- requirements
Module: tcm_mem

Interface
REQ-001 SHALL have no parameters; storage fixed at 128 KiB, organised as 16384 x 64-bit little-endian words.
REQ-002 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 mem_i_rd_i  input  1  instruction fetch request.
REQ-005 mem_i_flush_i, mem_i_invalidate_i  input  1 each  I-side cache maintenance hints.
REQ-006 mem_i_pc_i  input  32  fetch byte address.
REQ-007 mem_d_addr_i  input  32  data byte address.
REQ-008 mem_d_data_wr_i  input  32  write data.
REQ-009 mem_d_rd_i  input  1  data read request.
REQ-010 mem_d_wr_i  input  4  byte write enables; bit n covers data bits 8n+7:8n.
REQ-011 mem_d_cacheable_i  input  1  attribute, ignored.
REQ-012 mem_d_req_tag_i  input  11  request tag.
REQ-013 mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i  input  1 each  D-side cache maintenance requests.
REQ-014 mem_i_accept_o  output  1  fetch accepted.
REQ-015 mem_i_valid_o  output  1  fetch response valid.
REQ-016 mem_i_error_o  output  1  fetch error.
REQ-017 mem_i_inst_o  output  64  fetched doubleword.
REQ-018 mem_d_data_rd_o  output  32  read data.
REQ-019 mem_d_accept_o  output  1  data request accepted.
REQ-020 mem_d_ack_o  output  1  data response valid.
REQ-021 mem_d_error_o  output  1  data error.
REQ-022 mem_d_resp_tag_o  output  11  echoed tag.
REQ-023 SHALL provide a simulation task write(addr[31:0], data[7:0]) storing one byte at addr[16:0], usable any time for preload.

Function
REQ-024 Address decode: only bits [16:0] used; upper bits ignored (0x80000000 maps to offset 0; offsets wrap modulo 128 KiB).
REQ-025 mem_i_accept_o and mem_d_accept_o SHALL be constant 1; no back-pressure.
REQ-026 mem_i_error_o and mem_d_error_o SHALL be constant 0.
REQ-027 Fetch: mem_i_rd_i=1 at edge N -> at N+1 mem_i_valid_o=1, mem_i_inst_o = 64-bit word at pc[16:3] (pc[2:0] ignored); mem_i_valid_o=0 in cycles without a request; fetch requests back-to-back every cycle.
REQ-028 Data request = mem_d_rd_i or any mem_d_wr_i bit or flush/invalidate/writeback; at edge N -> at N+1 mem_d_ack_o=1, mem_d_resp_tag_o=req_tag; ack 0 otherwise; one request per cycle sustained.
REQ-029 Data read: mem_d_data_rd_o = 32-bit half selected by addr[2] (0 low, 1 high) of word addr[16:3]; addr[1:0] ignored.
REQ-030 Data write: bytes with wr bit set updated at edge N; data_rd for that request returns the pre-write value (read-first).
REQ-031 Maintenance-only requests (flush/invalidate/writeback, no rd/wr) SHALL ack with no memory change; mem_i_flush_i/mem_i_invalidate_i have no effect.
REQ-032 Same-cycle fetch and data write to same word: fetch returns pre-write contents; write completes.
REQ-033 mem_d_data_rd_o and mem_i_inst_o SHALL hold their last value when no response.

Reset
REQ-034 rst_i=1 SHALL immediately force mem_i_valid_o=0, mem_d_ack_o=0, mem_d_resp_tag_o=0, mem_d_data_rd_o=0, mem_i_inst_o=0.
REQ-035 Reset SHALL NOT clear storage; a request in flight when reset asserts is dropped (no ack after release).
REQ-036 task write SHALL function during and after reset.

Verification
REQ-037 Preload bytes 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00 at 0..7; fetch pc 0x80000000 -> next cycle valid=1, inst=0x0010009300000013.
REQ-038 Write 0xDEADBEEF, wr=0xF, addr 0x80000104, tag 0x155 -> ack next cycle, resp_tag 0x155; read same addr -> 0xDEADBEEF; fetch 0x80000100 -> inst[63:32]=0xDEADBEEF.
REQ-039 Word 0x11223344 at 0x200, write 0xAABBCCDD wr=0x5 -> read returns 0x11BB33DD; that write's own response returned 0x11223344.
REQ-040 Address 0x80020010 reads same data as 0x80000010 (wrap).
REQ-041 flush only, tag 0x7FF -> ack=1, resp_tag 0x7FF, memory unchanged; accept outputs 1 and error outputs 0 throughout.
REQ-042 Assert rst_i mid-request -> valid/ack drop to 0 without clock edge; preloaded data still readable after release.
